spi_target_rx_fifo: RTL and testbench

//  SPI target (slave) end of the SPI link, mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_target_rx_fifo_if.sv | 27 ++
 rtl/spi_target_rx_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_target_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_target_rx_fifo_if.sv
// User-side bundle of the SPI target: TX holding-word handshake and RX FIFO read port.
// The master modport is the on-chip logic; the slave modport is the SPI target block.
interface spi_target_rx_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
);
   logic [WIDTH-1:0]         tx_data;
   logic                     tx_valid;
   logic                     tx_ready;
   logic                     rd_en;
   logic [WIDTH-1:0]         dout;
   logic                     valid;
   logic                     empty;
   logic                     full;
   logic [$clog2(DEPTH):0]   data_count;
   logic                     overrun;

   modport master (
      output tx_data, tx_valid, rd_en,
      input  tx_ready, dout, valid, empty, full, data_count, overrun
   );

   modport slave (
      input  tx_data, tx_valid, rd_en,
      output tx_ready, dout, valid, empty, full, data_count, overrun
   );
endinterface

// File: rtl/spi_target_rx_fifo.sv
// SPI mode-0 target, MSB first, oversampled in the clk domain.
// Completed RX words land in a circular FIFO; a TX holding word is shifted out on MISO.
module spi_target_rx_fifo #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   spi_target_rx_fifo_if.slave   bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [BW-1:0] BIT_END  = BW'(WIDTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Pin synchronizers; bundle bit order is {mosi, cs_n, sclk}
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][2:0] sync_reg;
   logic [SYNC_STAGES-1:0][2:0] sync_d;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_d[gi] = {spi_mosi, spi_cs_n, spi_sclk};
         end else begin : g_rest
            assign sync_d[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   // cs_n resets to "selected" so a real deselect must be seen before joining a frame
   always_ff @(posedge clk) begin
      if (!srst) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= sync_d;
      end
   end

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   logic sclk_hist_reg;
   logic cs_hist_reg;

   assign sclk_s = sync_reg[SYNC_STAGES-1][0];
   assign cs_s   = sync_reg[SYNC_STAGES-1][1];
   assign mosi_s = sync_reg[SYNC_STAGES-1][2];

   always_ff @(posedge clk) begin
      if (!srst) begin
         sclk_hist_reg <= 1'b0;
         cs_hist_reg   <= 1'b0;
      end else begin
         sclk_hist_reg <= sclk_s;
         cs_hist_reg   <= cs_s;
      end
   end

   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;

   assign sclk_rise = sclk_s & ~sclk_hist_reg;
   assign sclk_fall = ~sclk_s & sclk_hist_reg;
   assign cs_rise   = cs_s & ~cs_hist_reg;
   assign cs_fall   = ~cs_s & cs_hist_reg;

   // ------------------------------------------------------------------
   // Frame state machine and shift registers
   // ------------------------------------------------------------------
   state_t            state_reg;
   state_t            state_next;
   logic [WIDTH-1:0]  tx_shift_reg;
   logic [WIDTH-1:0]  tx_shift_next;
   logic [WIDTH-1:0]  rx_shift_reg;
   logic [WIDTH-1:0]  rx_shift_next;
   logic [BW-1:0]     bit_cnt_reg;
   logic [BW-1:0]     bit_cnt_next;
   logic              push_reg;
   logic              push_next;
   logic              load;

   always_comb begin
      state_next    = state_reg;
      tx_shift_next = tx_shift_reg;
      rx_shift_next = rx_shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      push_next     = 1'b0;
      load          = 1'b0;

      case (state_reg)
         WAIT_IDLE: begin
            if (cs_s) begin
               state_next = IDLE;
            end
         end
         IDLE: begin
            if (cs_fall) begin
               state_next   = SHIFT;
               load         = 1'b1;
               bit_cnt_next = '0;
            end
         end
         SHIFT: begin
            // Deselect has priority over any SCLK edge seen in the same cycle
            if (cs_rise) begin
               state_next   = IDLE;
               bit_cnt_next = '0;
            end else if (sclk_rise) begin
               rx_shift_next = {rx_shift_reg[WIDTH-2:0], mosi_s};
               bit_cnt_next  = bit_cnt_reg + 1'b1;
               if (bit_cnt_reg == BIT_LAST) begin
                  push_next = 1'b1;
               end
            end else if (sclk_fall) begin
               tx_shift_next = tx_shift_reg << 1;
               if (bit_cnt_reg == BIT_END) begin
                  load         = 1'b1;
                  bit_cnt_next = '0;
               end
            end
         end
         default: begin
            state_next = WAIT_IDLE;
         end
      endcase

      if (load) begin
         tx_shift_next = bus.tx_valid ? bus.tx_data : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!srst) begin
         state_reg    <= WAIT_IDLE;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         bit_cnt_reg  <= '0;
         push_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tx_shift_reg <= tx_shift_next;
         rx_shift_reg <= rx_shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         push_reg     <= push_next;
      end
   end

   assign bus.tx_ready = load & bus.tx_valid & srst;
   assign spi_miso_oe  = (state_reg == SHIFT);
   assign spi_miso     = (state_reg == SHIFT) & tx_shift_reg[WIDTH-1];

   // ------------------------------------------------------------------
   // RX FIFO; the completed word stays in rx_shift_reg for the push cycle
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    wr_ptr_reg;
   logic [CW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count;
   logic             empty_w;
   logic             full_w;
   logic             wr_en;
   logic             rd_fire;
   logic [WIDTH-1:0] dout_reg;
   logic             valid_reg;
   logic             overrun_reg;

   assign count   = wr_ptr_reg - rd_ptr_reg;
   assign empty_w = (count == '0);
   assign full_w  = (count == CNT_FULL);
   assign wr_en   = push_reg & ~full_w;
   assign rd_fire = bus.rd_en & ~empty_w;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg[AW-1:0]] <= rx_shift_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (!srst) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         dout_reg    <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            dout_reg   <= mem[rd_ptr_reg[AW-1:0]];
         end
         valid_reg   <= rd_fire;
         overrun_reg <= push_reg & full_w;
      end
   end

   assign bus.dout       = dout_reg;
   assign bus.valid      = valid_reg;
   assign bus.empty      = empty_w;
   assign bus.full       = full_w;
   assign bus.data_count = count;
   assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_spi_target_rx_fifo.sv
// Directed bench for spi_target_rx_fifo: table of single-word frames plus
// hand-written multi-word, overflow, abort and mid-frame reset sequences.
module tb_spi_target_rx_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic clk  = 1'b0;
   logic srst = 1'b0;
   logic sclk = 1'b0;
   logic cs_n = 1'b1;
   logic mosi = 1'b0;
   logic miso;
   logic miso_oe;

   spi_target_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

   spi_target_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .srst        (srst),
      .spi_sclk    (sclk),
      .spi_cs_n    (cs_n),
      .spi_mosi    (mosi),
      .spi_miso    (miso),
      .spi_miso_oe (miso_oe),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int txr_cnt  = 0;
   int ovr_cnt  = 0;

   always @(negedge clk) begin
      if (bus_if.tx_ready) txr_cnt++;
      if (bus_if.overrun)  ovr_cnt++;
   end

   typedef struct {
      logic [7:0] mosi_w;
      logic [7:0] tx_w;
      logic       txv;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      wait_clk(4);
      m = miso;
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
   endtask

   task automatic spi_word(input logic [7:0] w, output logic [7:0] r);
      logic m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(w[i], m);
         r[i] = m;
      end
   endtask

   // tx_valid is withdrawn once the CS-fall load has happened
   task automatic start_frame();
      cs_n = 1'b0;
      wait_clk(6);
      bus_if.tx_valid = 1'b0;
   endtask

   task automatic end_frame();
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic pop_chk(input string name, input logic [7:0] exp);
      bus_if.rd_en = 1'b1;
      wait_clk(1);
      bus_if.rd_en = 1'b0;
      chk({name, "_valid"}, 32'(bus_if.valid), 32'd1);
      chk({name, "_dout"}, 32'(bus_if.dout), 32'(exp));
      $display("pop %s dout=0x%02h valid=%0b", name, bus_if.dout, bus_if.valid);
      wait_clk(1);
      chk({name, "_valid_pulse"}, 32'(bus_if.valid), 32'd0);
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] r1;
      logic [7:0] r2;
      logic [7:0] words [5];
      logic       m;
      logic       oe_dropped;
      int         t0;
      int         o0;

      vecs[0] = '{8'h3C, 8'hA5, 1'b1, 8'hA5, 8'h3C};
      vecs[1] = '{8'hC3, 8'h77, 1'b0, 8'h00, 8'hC3};
      vecs[2] = '{8'hFF, 8'h5A, 1'b1, 8'h5A, 8'hFF};
      vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 8'h00};
      vecs[4] = '{8'h81, 8'h7E, 1'b1, 8'h7E, 8'h81};
      words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

      bus_if.tx_data  = '0;
      bus_if.tx_valid = 1'b0;
      bus_if.rd_en    = 1'b0;

      // Reset
      wait_clk(4);
      chk("rst_empty", 32'(bus_if.empty), 32'd1);
      chk("rst_full", 32'(bus_if.full), 32'd0);
      chk("rst_count", 32'(bus_if.data_count), 32'd0);
      chk("rst_oe", 32'(miso_oe), 32'd0);
      chk("rst_miso", 32'(miso), 32'd0);
      chk("rst_dout", 32'(bus_if.dout), 32'd0);
      chk("rst_tx_ready", 32'(bus_if.tx_ready), 32'd0);
      chk("rst_valid", 32'(bus_if.valid), 32'd0);
      chk("rst_overrun", 32'(bus_if.overrun), 32'd0);
      srst = 1'b1;
      wait_clk(6);

      // Single-word frames from the table
      for (int v = 0; v < 5; v++) begin
         bus_if.tx_data  = vecs[v].tx_w;
         bus_if.tx_valid = vecs[v].txv;
         t0 = txr_cnt;
         start_frame();
         spi_word(vecs[v].mosi_w, r);
         end_frame();
         $display("frame %0d mosi=0x%02h miso=0x%02h count=%0d", v, vecs[v].mosi_w, r, bus_if.data_count);
         chk($sformatf("v%0d_miso", v), 32'(r), 32'(vecs[v].exp_miso));
         chk($sformatf("v%0d_tx_ready", v), 32'(txr_cnt - t0), 32'(vecs[v].txv));
         chk($sformatf("v%0d_count", v), 32'(bus_if.data_count), 32'd1);
         chk($sformatf("v%0d_oe_idle", v), 32'(miso_oe), 32'd0);
         pop_chk($sformatf("v%0d", v), vecs[v].exp_rx);
         chk($sformatf("v%0d_empty", v), 32'(bus_if.empty), 32'd1);
      end

      // Three words in one frame, TX word offered only before the frame
      bus_if.tx_data  = 8'hA5;
      bus_if.tx_valid = 1'b1;
      t0 = txr_cnt;
      start_frame();
      spi_word(8'h01, r);
      spi_word(8'h02, r1);
      spi_word(8'h03, r2);
      end_frame();
      $display("frame multi miso=0x%02h 0x%02h 0x%02h count=%0d", r, r1, r2, bus_if.data_count);
      chk("multi_miso0", 32'(r), 32'hA5);
      chk("multi_miso1", 32'(r1), 32'h00);
      chk("multi_miso2", 32'(r2), 32'h00);
      chk("multi_tx_ready", 32'(txr_cnt - t0), 32'd1);
      chk("multi_count", 32'(bus_if.data_count), 32'd3);
      pop_chk("multi_w0", 8'h01);
      pop_chk("multi_w1", 8'h02);
      pop_chk("multi_w2", 8'h03);

      // Overflow: five words into a four-entry FIFO
      o0 = ovr_cnt;
      for (int k = 0; k < 5; k++) begin
         start_frame();
         spi_word(words[k], r);
         end_frame();
         $display("frame ovf %0d mosi=0x%02h count=%0d full=%0b", k, words[k], bus_if.data_count, bus_if.full);
         if (k == 2) chk("ovf_not_full3", 32'(bus_if.full), 32'd0);
         if (k == 3) chk("ovf_full4", 32'(bus_if.full), 32'd1);
         if (k == 3) chk("ovf_overrun_none", 32'(ovr_cnt - o0), 32'd0);
      end
      chk("ovf_overrun_once", 32'(ovr_cnt - o0), 32'd1);
      chk("ovf_count", 32'(bus_if.data_count), 32'd4);
      chk("ovf_full", 32'(bus_if.full), 32'd1);
      pop_chk("ovf_w0", 8'h11);
      chk("ovf_full_after_pop", 32'(bus_if.full), 32'd0);
      pop_chk("ovf_w1", 8'h22);
      pop_chk("ovf_w2", 8'h33);
      pop_chk("ovf_w3", 8'h44);
      chk("ovf_empty", 32'(bus_if.empty), 32'd1);
      bus_if.rd_en = 1'b1;
      wait_clk(1);
      bus_if.rd_en = 1'b0;
      chk("empty_pop_valid", 32'(bus_if.valid), 32'd0);
      chk("empty_pop_dout_hold", 32'(bus_if.dout), 32'h44);
      chk("empty_pop_count", 32'(bus_if.data_count), 32'd0);

      // Abort after five SCLK edges
      start_frame();
      spi_bit(1'b1, m);
      spi_bit(1'b0, m);
      mosi = 1'b1;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      chk("abort_oe_before", 32'(miso_oe), 32'd1);
      cs_n = 1'b1;
      oe_dropped = 1'b0;
      for (int c = 0; c < 3; c++) begin
         wait_clk(1);
         if (!miso_oe) oe_dropped = 1'b1;
      end
      chk("abort_oe_drop", 32'(oe_dropped), 32'd1);
      sclk = 1'b0;
      wait_clk(8);
      $display("frame abort count=%0d oe=%0b", bus_if.data_count, miso_oe);
      chk("abort_no_push", 32'(bus_if.data_count), 32'd0);
      bus_if.tx_data  = 8'h3C;
      bus_if.tx_valid = 1'b1;
      start_frame();
      spi_word(8'hC3, r);
      end_frame();
      $display("frame after_abort mosi=0xc3 miso=0x%02h count=%0d", r, bus_if.data_count);
      chk("after_abort_miso", 32'(r), 32'h3C);
      chk("after_abort_count", 32'(bus_if.data_count), 32'd1);
      pop_chk("after_abort", 8'hC3);

      // Reset in the middle of a frame with cs_n held low
      start_frame();
      spi_bit(1'b0, m);
      spi_bit(1'b1, m);
      spi_bit(1'b0, m);
      chk("midrst_oe_before", 32'(miso_oe), 32'd1);
      srst = 1'b0;
      wait_clk(2);
      srst = 1'b1;
      wait_clk(8);
      chk("midrst_oe", 32'(miso_oe), 32'd0);
      for (int b = 0; b < 5; b++) spi_bit(1'b1, m);
      wait_clk(8);
      $display("frame midrst count=%0d oe=%0b", bus_if.data_count, miso_oe);
      chk("midrst_no_push", 32'(bus_if.data_count), 32'd0);
      chk("midrst_oe_still", 32'(miso_oe), 32'd0);
      cs_n = 1'b1;
      wait_clk(8);
      bus_if.tx_data  = 8'hC3;
      bus_if.tx_valid = 1'b1;
      start_frame();
      spi_word(8'h5A, r);
      end_frame();
      $display("frame after_rst mosi=0x5a miso=0x%02h count=%0d", r, bus_if.data_count);
      chk("after_rst_miso", 32'(r), 32'hC3);
      chk("after_rst_count", 32'(bus_if.data_count), 32'd1);
      pop_chk("after_rst", 8'h5A);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
